dmem_bus_responder: RTL and testbench
=====================================

DMEM_BUS_RESPONDER -- requirements
Module: dmem_bus_responder

Interface
REQ-001 The block SHALL have a parameter READ_LAT, default 2: cycles from read accept to read response, legal range 1..15.
REQ-002 The block SHALL have a parameter WRITE_LAT, default 2: number of cycles dbusy is high per write, legal range 1..15.
REQ-003 The block SHALL have a parameter AW, default 10: word-index width, giving a memory depth of 2^AW 32-bit words.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port MemRW, input, 2 bits: bit1 is read request, bit0 is write request, held stable by the pipeline while stalled.
REQ-007 The block SHALL have port daddr, input, 32 bits: byte address, held stable with MemRW.
REQ-008 The block SHALL have port wdata, input, 32 bits: write data.
REQ-009 The block SHALL have port wstrb, input, 4 bits: byte-write enables; bit n selects byte n.
REQ-010 The block SHALL have port rdata, output, 32 bits: read data, registered.
REQ-011 The block SHALL have port dready_n, output, 1 bit: active-low read-response strobe, registered.
REQ-012 The block SHALL have port dbusy, output, 1 bit: write-in-progress stall request.
REQ-013 The block SHALL have port err_proto, output, 1 bit: sticky protocol-error flag.
REQ-014 The block SHALL have ports rd_count and wr_count, outputs, 16 bits each: saturating counts of completed reads and completed writes.

Function
REQ-015 The state machine SHALL have the states IDLE, RWAIT, RESP, WWAIT and WACK.
REQ-016 Requests SHALL be accepted only in IDLE, on a clock edge where MemRW is nonzero. Any request visible in RESP or WACK SHALL be ignored.
REQ-017 The word index SHALL be daddr[AW+1:2]. daddr[1:0] and the bits above AW+1 SHALL be ignored, so higher addresses alias.
REQ-018 Read accept SHALL latch the index. dready_n SHALL go low for exactly one cycle (state RESP), starting after READ_LAT edges counting the accept edge. rdata SHALL hold mem[index] in that cycle.
REQ-019 After RESP the block SHALL return to IDLE. rdata SHALL hold its value until the next read response.
REQ-020 dready_n SHALL be 1 in every state except RESP.
REQ-021 dbusy SHALL be combinational and equal 1 in the following cases:
- in IDLE when MemRW[0]=1 and MemRW[1]=0;
- in WWAIT.
REQ-022 dbusy SHALL be 1 for exactly WRITE_LAT cycles per write, accept cycle included.
REQ-023 The memory write SHALL occur on the edge that ends the last dbusy cycle. Only bytes with wstrb[n]=1 SHALL be updated, using wdata and wstrb sampled at the accept edge.
REQ-024 After the commit edge, the block SHALL spend exactly one cycle in WACK with dbusy=0, then return to IDLE.
REQ-025 MemRW=2'b11 SHALL be serviced as a read with no write performed, and SHALL set err_proto=1 at the accept edge.
REQ-026 err_proto SHALL remain 1 until reset.
REQ-027 rd_count SHALL increment on entry to RESP, and wr_count SHALL increment on the commit edge.
REQ-028 rd_count and wr_count SHALL saturate at 16'hFFFF with no wrap.
REQ-029 Back-to-back requests with MemRW held constant SHALL be serviced as distinct transactions: the next accept is the first IDLE edge after RESP or WACK.
REQ-030 Memory contents SHALL NOT be initialised or altered by reset.

Reset
REQ-031 While rst=0, the outputs SHALL be:
- state=IDLE, dready_n=1, dbusy=0 (forced, overriding REQ-021);
- rdata=0, err_proto=0, rd_count=0, wr_count=0.
REQ-032 Reset asserted mid-RWAIT or mid-WWAIT SHALL abort the transaction with no memory write and no count change. A request still held after release SHALL be accepted as new on the first edge with rst=1.

Verification
REQ-033 Defaults; write daddr=0x10, wdata=0xDEADBEEF, wstrb=4'hF -> dbusy=1 for 2 cycles, one WACK cycle with dbusy=0, mem[4]=0xDEADBEEF, wr_count=1.
REQ-034 Read daddr=0x10 -> dready_n=1 in the accept cycle and one more cycle, then dready_n=0 for 1 cycle with rdata=0xDEADBEEF, rd_count=1.
REQ-035 Write 0x000000AA with wstrb=4'b0001 to 0x10, then read 0x10 -> rdata=0xDEADBEAA.
REQ-036 Reads to 0x10 then 0x14 with MemRW held at 2'b10 -> two separate one-cycle dready_n pulses, rd_count=2. A read of 0x1010 (AW=10) -> same data as 0x10.
REQ-037 MemRW=2'b11 at daddr=0x10 -> read response 0xDEADBEAA, memory unchanged, wr_count unchanged, err_proto=1 and still 1 after 10 idle cycles.
REQ-038 rst=0 during WWAIT of a write of 0x12345678 to 0x10 -> all outputs at reset values immediately, mem[4] unchanged. After release with the request still held, the write completes normally and wr_count=1.

Source files
------------

// File: rtl/dmem_bus_responder.sv
// ============================================================================
// Module   : dmem_bus_responder
// Summary  : Data-memory bus responder with fixed read/write latency, byte
//            strobes, sticky protocol-error flag and saturating counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_bus_responder #(
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 2,
  parameter int AW        = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  MemRW,
  input  logic [31:0] daddr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic [31:0] rdata,
  output logic        dready_n,
  output logic        dbusy,
  output logic        err_proto,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RWAIT = 3'd1,
    S_RESP  = 3'd2,
    S_WWAIT = 3'd3,
    S_WACK  = 3'd4
  } state_t;

  // Wait-state counters run down to zero, so they start at latency-2.
  localparam logic [3:0] c_RINIT = 4'((READ_LAT  > 1) ? READ_LAT  - 2 : 0);
  localparam logic [3:0] c_WINIT = 4'((WRITE_LAT > 1) ? WRITE_LAT - 2 : 0);

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_cnt;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wdata;
  logic [3:0]      r_wstrb;
  logic [31:0]     r_rdata;
  logic            r_dready_n;
  logic            r_err;
  logic [15:0]     r_rd_cnt;
  logic [15:0]     r_wr_cnt;
  logic [31:0]     r_mem [2**AW];

  logic [AW-1:0]   w_idx;
  logic            w_dbusy;
  logic            w_mem_we;
  logic [AW-1:0]   w_we_idx;
  logic [31:0]     w_we_data;
  logic [3:0]      w_we_strb;
  logic            w_rd_fire;
  logic [AW-1:0]   w_rd_idx;
  logic            w_accept;
  logic            w_unused_addr;

  assign w_idx         = daddr[AW+1:2];
  assign w_unused_addr = ^{daddr[31:AW+2], daddr[1:0]};
  assign w_accept      = (r_state == S_IDLE) && (MemRW != 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_dbusy   = 1'b0;
    w_mem_we  = 1'b0;
    w_we_idx  = r_idx;
    w_we_data = r_wdata;
    w_we_strb = r_wstrb;
    w_rd_fire = 1'b0;
    w_rd_idx  = r_idx;
    case (r_state)
      S_IDLE: begin
        if (MemRW[1]) begin
          if (READ_LAT == 1) begin
            w_next    = S_RESP;
            w_rd_fire = 1'b1;
            w_rd_idx  = w_idx;
          end else begin
            w_next = S_RWAIT;
          end
        end else if (MemRW[0]) begin
          w_dbusy = 1'b1;
          if (WRITE_LAT == 1) begin
            w_next    = S_WACK;
            w_mem_we  = 1'b1;
            w_we_idx  = w_idx;
            w_we_data = wdata;
            w_we_strb = wstrb;
          end else begin
            w_next = S_WWAIT;
          end
        end
      end
      S_RWAIT: begin
        if (r_cnt == 4'd0) begin
          w_next    = S_RESP;
          w_rd_fire = 1'b1;
        end
      end
      S_RESP:  w_next = S_IDLE;
      S_WWAIT: begin
        w_dbusy = 1'b1;
        if (r_cnt == 4'd0) begin
          w_next   = S_WACK;
          w_mem_we = 1'b1;
        end
      end
      S_WACK:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Reset must override the request-driven stall even while state is IDLE.
  assign dbusy = w_dbusy & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= 4'd0;
      r_idx      <= '0;
      r_wdata    <= 32'd0;
      r_wstrb    <= 4'd0;
      r_rdata    <= 32'd0;
      r_dready_n <= 1'b1;
      r_err      <= 1'b0;
      r_rd_cnt   <= 16'd0;
      r_wr_cnt   <= 16'd0;
    end else begin
      if (w_accept) begin
        r_idx   <= w_idx;
        r_wdata <= wdata;
        r_wstrb <= wstrb;
        r_cnt   <= MemRW[1] ? c_RINIT : c_WINIT;
      end else if (((r_state == S_RWAIT) || (r_state == S_WWAIT)) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_accept && (MemRW == 2'b11)) r_err <= 1'b1;
      r_dready_n <= (w_next != S_RESP);
      if (w_rd_fire) begin
        r_rdata <= r_mem[w_rd_idx];
        if (r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
      end
      if (w_mem_we && (r_wr_cnt != 16'hFFFF)) r_wr_cnt <= r_wr_cnt + 16'd1;
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (w_mem_we && rst) begin
      for (int b = 0; b < 4; b++) begin
        if (w_we_strb[b]) r_mem[w_we_idx][8*b +: 8] <= w_we_data[8*b +: 8];
      end
    end
  end

  assign rdata     = r_rdata;
  assign dready_n  = r_dready_n;
  assign err_proto = r_err;
  assign rd_count  = r_rd_cnt;
  assign wr_count  = r_wr_cnt;

endmodule

`default_nettype wire

// File: tb/tb_dmem_bus_responder.sv
// ============================================================================
// Module   : tb_dmem_bus_responder
// Summary  : Scoreboard testbench for dmem_bus_responder (default parameters).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_dmem_bus_responder;
  localparam int READ_LAT  = 2;
  localparam int WRITE_LAT = 2;
  localparam int AW        = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  MemRW = 2'b00;
  logic [31:0] daddr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  wstrb = 4'd0;
  logic [31:0] rdata;
  logic        dready_n;
  logic        dbusy;
  logic        err_proto;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  int          checks = 0;
  int          errors = 0;
  int          exp_rd = 0;
  int          exp_wr = 0;
  logic [31:0] sb_q[$];
  logic [31:0] m_mem [1024];

  dmem_bus_responder #(.READ_LAT(READ_LAT), .WRITE_LAT(WRITE_LAT), .AW(AW)) u_dut (
    .clk(clk), .rst(rst), .MemRW(MemRW), .daddr(daddr), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata), .dready_n(dready_n), .dbusy(dbusy), .err_proto(err_proto),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic int widx(input logic [31:0] a);
    return int'(a[AW+1:2]);
  endfunction

  // Inputs are driven just after a falling edge; outputs sampled 1 time unit later.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    MemRW = 2'b01; daddr = a; wdata = d; wstrb = s;
    #1;
    checks++;
    if (dbusy !== 1'b1) begin errors++; $display("FAIL wr_accept_dbusy got %b exp 1", dbusy); end
    n = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (dbusy === 1'b1) n++;
      else break;
    end
    for (int b = 0; b < 4; b++) if (s[b]) m_mem[widx(a)][8*b +: 8] = d[8*b +: 8];
    if (exp_wr < 65535) exp_wr++;
    checks++;
    if (n != WRITE_LAT) begin errors++; $display("FAIL wr_busy_cycles got %0d exp %0d", n, WRITE_LAT); end
    checks++;
    if (wr_count !== 16'(exp_wr)) begin errors++; $display("FAIL wr_count got %0d exp %0d", wr_count, exp_wr); end
    MemRW = 2'b00;
    @(negedge clk); #1;
    checks++;
    if (dbusy !== 1'b0) begin errors++; $display("FAIL wr_idle_dbusy got %b exp 0", dbusy); end
  endtask

  task automatic do_read(input logic [31:0] a, input logic [1:0] rw, input bit hold);
    int          k;
    logic [31:0] exp_d;
    MemRW = rw; daddr = a;
    sb_q.push_back(m_mem[widx(a)]);
    #1;
    checks++;
    if (dready_n !== 1'b1) begin errors++; $display("FAIL rd_accept_dready_n got %b exp 1", dready_n); end
    for (k = 1; k <= 20; k++) begin
      @(negedge clk); #1;
      if (dready_n === 1'b0) break;
    end
    checks++;
    if (k != READ_LAT) begin errors++; $display("FAIL rd_latency got %0d exp %0d", k, READ_LAT); end
    if (exp_rd < 65535) exp_rd++;
    exp_d = sb_q.pop_front();
    checks++;
    if (rdata !== exp_d) begin errors++; $display("FAIL rd_data addr %h got %h exp %h", a, rdata, exp_d); end
    checks++;
    if (rd_count !== 16'(exp_rd)) begin errors++; $display("FAIL rd_count got %0d exp %0d", rd_count, exp_rd); end
    if (!hold) MemRW = 2'b00;
    @(negedge clk); #1;
    checks++;
    if (dready_n !== 1'b1 || rdata !== exp_d) begin
      errors++; $display("FAIL rd_after_resp dready_n %b rdata %h exp 1 %h", dready_n, rdata, exp_d);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (dready_n !== 1'b1 || dbusy !== 1'b0 || rdata !== 32'd0 || err_proto !== 1'b0 ||
        rd_count !== 16'd0 || wr_count !== 16'd0) begin
      errors++;
      $display("FAIL %s got dready_n %b dbusy %b rdata %h err %b rd %0d wr %0d exp 1 0 0 0 0 0",
               tag, dready_n, dbusy, rdata, err_proto, rd_count, wr_count);
    end
  endtask

  task automatic test_reset();
    MemRW = 2'b01;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset_values");
    MemRW = 2'b00;
    rst = 1'b1;
    @(negedge clk); #1;
  endtask

  task automatic test_write();
    do_write(32'h10, 32'hDEADBEEF, 4'hF);
  endtask

  task automatic test_read();
    do_read(32'h10, 2'b10, 1'b0);
  endtask

  task automatic test_strobe();
    do_write(32'h10, 32'h000000AA, 4'b0001);
    do_read(32'h10, 2'b10, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_write(32'h14, 32'h0BADF00D, 4'hF);
    do_read(32'h10, 2'b10, 1'b1);
    do_read(32'h14, 2'b10, 1'b0);
    do_read(32'h1010, 2'b10, 1'b0);
  endtask

  task automatic test_proto();
    int w0;
    w0 = exp_wr;
    do_read(32'h10, 2'b11, 1'b0);
    checks++;
    if (err_proto !== 1'b1) begin errors++; $display("FAIL err_proto_set got %b exp 1", err_proto); end
    checks++;
    if (wr_count !== 16'(w0)) begin errors++; $display("FAIL proto_wr_count got %0d exp %0d", wr_count, w0); end
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (err_proto !== 1'b1) begin errors++; $display("FAIL err_proto_sticky got %b exp 1", err_proto); end
    do_read(32'h10, 2'b10, 1'b0);
  endtask

  task automatic test_reset_abort();
    MemRW = 2'b01; daddr = 32'h10; wdata = 32'h12345678; wstrb = 4'hF;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("abort_reset_values");
    exp_rd = 0; exp_wr = 0;
    MemRW = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    do_read(32'h10, 2'b10, 1'b0);
  endtask

  task automatic test_reset_held();
    MemRW = 2'b01; daddr = 32'h10; wdata = 32'h12345678; wstrb = 4'hF;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_outputs("held_reset_values");
    exp_rd = 0; exp_wr = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    do_write(32'h10, 32'h12345678, 4'hF);
    do_read(32'h10, 2'b10, 1'b0);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_strobe();
    test_back_to_back();
    test_proto();
    test_reset_abort();
    test_reset_held();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
